fetch_stage: RTL

//   Instruction-fetch stage that sits directly upstream of InstructionMemory.
//   - Owns the program counter and drives the byte address to InstructionMemory.
//   - Captures the returned word into an IF/ID register, with a valid bit and PC+4.
//   - Handles stall, branch/jump redirect (with flush), and target-alignment checking.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_stage_if.sv | 18 +
 rtl/pc_next_mux.sv | 26 ++
 rtl/fetch_stage.sv | 88 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
// Reset vector, flush word, PC step and the J-type opcode.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [5:0]  OPC_J        = 6'h02;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch and InstructionMemory.
// The master drives the byte address; the slave returns the word.
interface fetch_stage_if;

  logic [31:0] InstrAddr;
  logic [31:0] InstrData;

  modport master (
    output InstrAddr,
    input  InstrData
  );

  modport slave (
    input  InstrAddr,
    output InstrData
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC select for the fetch stage.
// Priority: jump, then branch, then stall, else sequential.
module pc_next_mux
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  output logic [31:0] pc_o
);

  always_comb begin
    pc_o = pc_i + PC_STEP;
    if (jump_i) begin
      pc_o = jump_tgt_i;
    end else if (branch_i) begin
      pc_o = target_i & ~32'h3;
    end else if (stall_i) begin
      pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives InstructionMemory
// and loads the IF/ID register with stall, redirect and flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic [31:0]   BranchTarget,
  input  logic          Jump,
  input  logic [25:0]   JumpIndex,
  fetch_stage_if.master imem,
  output logic [31:0]   IdInstruction,
  output logic [31:0]   IdPCPlus4,
  output logic          IdValid,
  output logic          AlignErr,
  output logic [31:0]   FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        aerr_q;
  logic [31:0] cnt_q;
  logic [31:0] jmp_tgt;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;
  // J-type target takes its region bits from the jump's own PC+4
  assign jmp_tgt  = {pc4_q[31:28], JumpIndex, 2'b00};

  pc_next_mux u_pc_next_mux (
    .pc_i       (pc_q),
    .stall_i    (Stall),
    .branch_i   (BranchTaken),
    .target_i   (BranchTarget),
    .jump_i     (Jump),
    .jump_tgt_i (jmp_tgt),
    .pc_o       (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      pc_q <= pc_d;
      priority case (1'b1)
        Jump: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        BranchTaken: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
          if (|BranchTarget[1:0]) begin
            aerr_q <= 1'b1;
          end
        end
        Stall: begin
        end
        default: begin
          instr_q <= imem.InstrData;
          pc4_q   <= pc_plus4;
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 32'd1;
        end
      endcase
    end
  end

  assign imem.InstrAddr = pc_q;
  assign IdInstruction  = instr_q;
  assign IdPCPlus4      = pc4_q;
  assign IdValid        = valid_q;
  assign AlignErr       = aerr_q;
  assign FetchCount     = cnt_q;

endmodule
